// File: rtl/warp_barrier_ctrl.sv
// Barrier controller for the warp scheduler: arms named barriers, stalls arriving warps, releases on completion.
// Optional watchdog force-release of hung barriers is enabled with `define WARP_BARRIER_TIMEOUT_EN.
module warp_barrier_ctrl #(
    parameter int unsigned NUM_WARPS      = 32,
    parameter int unsigned NUM_BARRIERS   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                                               clk,
    input  logic                                               rst_n,
    input  logic                                               cfg_valid,
    output logic                                               cfg_ready,
    input  logic [((NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1)-1:0] cfg_barrier_id,
    input  logic [NUM_WARPS-1:0]                               cfg_warp_mask,
    input  logic                                               arrive_valid,
    output logic                                               arrive_ready,
    input  logic [5:0]                                         arrive_warp_id,
    input  logic [((NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1)-1:0] arrive_barrier_id,
    output logic                                               barrier_stall,
    output logic [NUM_WARPS-1:0]                               barrier_warp_mask,
    output logic                                               barrier_release_valid,
    output logic [NUM_WARPS-1:0]                               barrier_release_warp_mask,
    output logic                                               error_valid,
    output logic [1:0]                                         error_code,
    output logic [5:0]                                         error_warp_id,
    output logic [NUM_BARRIERS-1:0]                            armed_mask,
    output logic                                               timeout_valid,
    output logic [((NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1)-1:0] timeout_barrier_id
);

    localparam int unsigned BW = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1;

    localparam logic [1:0] ERR_NOT_ARMED = 2'd1;
    localparam logic [1:0] ERR_NON_PART  = 2'd2;
    localparam logic [1:0] ERR_DUP       = 2'd3;

    typedef enum logic {
        B_IDLE  = 1'b0,
        B_ARMED = 1'b1
    } bar_state_e;

    bar_state_e           state_q [NUM_BARRIERS];
    bar_state_e           state_d [NUM_BARRIERS];
    logic [NUM_WARPS-1:0] part_q  [NUM_BARRIERS];
    logic [NUM_WARPS-1:0] part_d  [NUM_BARRIERS];
    logic [NUM_WARPS-1:0] arr_q   [NUM_BARRIERS];
    logic [NUM_WARPS-1:0] arr_d   [NUM_BARRIERS];

    logic                    stall_d;
    logic [NUM_WARPS-1:0]    wmask_d;
    logic                    rel_v_d;
    logic [NUM_WARPS-1:0]    rel_m_d;
    logic                    err_v_d;
    logic [1:0]              err_c_d;
    logic [5:0]              err_w_d;
    logic [NUM_BARRIERS-1:0] armed_d;
    logic                    arr_ok;
    logic                    completed;

    logic                 cfg_fire;
    logic                 arr_fire;
    logic [NUM_WARPS-1:0] oh;

    // Handshake readies are combinational from the registered barrier state; cfg wins a same-barrier collision.
    assign cfg_ready    = (state_q[cfg_barrier_id] == B_IDLE);
    assign cfg_fire     = cfg_valid && cfg_ready;
    assign arrive_ready = !(cfg_fire && (cfg_barrier_id == arrive_barrier_id));
    assign arr_fire     = arrive_valid && arrive_ready;
    assign oh           = NUM_WARPS'(1) << arrive_warp_id;

`ifdef WARP_BARRIER_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q [NUM_BARRIERS];
    logic [CW-1:0] cnt_d [NUM_BARRIERS];
    logic          to_v_d;
    logic [BW-1:0] to_id_d;
    logic          found;
`endif

    // Next-state and registered-output computation
    always_comb begin
        for (int i = 0; i < NUM_BARRIERS; i++) begin
            state_d[i] = state_q[i];
            part_d[i]  = part_q[i];
            arr_d[i]   = arr_q[i];
        end
        stall_d   = 1'b0;
        wmask_d   = '0;
        rel_v_d   = 1'b0;
        rel_m_d   = '0;
        err_v_d   = 1'b0;
        err_c_d   = 2'd0;
        err_w_d   = 6'd0;
        armed_d   = '0;
        arr_ok    = 1'b0;
        completed = 1'b0;
`ifdef WARP_BARRIER_TIMEOUT_EN
        to_v_d  = 1'b0;
        to_id_d = '0;
        found   = 1'b0;
        for (int i = 0; i < NUM_BARRIERS; i++) begin
            if (state_q[i] == B_IDLE) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] != CW'(TIMEOUT_CYCLES)) begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end else begin
                cnt_d[i] = cnt_q[i];
            end
        end
`endif

        if (cfg_fire && (|cfg_warp_mask)) begin
            state_d[cfg_barrier_id] = B_ARMED;
            part_d[cfg_barrier_id]  = cfg_warp_mask;
            arr_d[cfg_barrier_id]   = '0;
`ifdef WARP_BARRIER_TIMEOUT_EN
            cnt_d[cfg_barrier_id]   = '0;
`endif
        end

        if (arr_fire) begin
            if (state_q[arrive_barrier_id] == B_IDLE) begin
                err_v_d = 1'b1;
                err_c_d = ERR_NOT_ARMED;
                err_w_d = arrive_warp_id;
            end else if (!(|(part_q[arrive_barrier_id] & oh))) begin
                err_v_d = 1'b1;
                err_c_d = ERR_NON_PART;
                err_w_d = arrive_warp_id;
            end else if (|(arr_q[arrive_barrier_id] & oh)) begin
                err_v_d = 1'b1;
                err_c_d = ERR_DUP;
                err_w_d = arrive_warp_id;
            end else if ((arr_q[arrive_barrier_id] | oh) != part_q[arrive_barrier_id]) begin
                arr_ok                    = 1'b1;
                arr_d[arrive_barrier_id]  = arr_q[arrive_barrier_id] | oh;
                stall_d                   = 1'b1;
                wmask_d                   = oh;
            end else begin
                arr_ok                     = 1'b1;
                completed                  = 1'b1;
                rel_v_d                    = 1'b1;
                rel_m_d                    = part_q[arrive_barrier_id];
                state_d[arrive_barrier_id] = B_IDLE;
                arr_d[arrive_barrier_id]   = '0;
                part_d[arrive_barrier_id]  = '0;
            end
`ifdef WARP_BARRIER_TIMEOUT_EN
            if (arr_ok) begin
                cnt_d[arrive_barrier_id] = '0;
            end
`endif
        end

`ifdef WARP_BARRIER_TIMEOUT_EN
        // Watchdog release: lowest saturated ID, only when no completion uses the release port
        if (!completed) begin
            for (int i = 0; i < NUM_BARRIERS; i++) begin
                if (!found && (state_q[i] == B_ARMED) && (cnt_q[i] == CW'(TIMEOUT_CYCLES))
                    && !(arr_ok && (arrive_barrier_id == BW'(i)))) begin
                    found      = 1'b1;
                    to_v_d     = 1'b1;
                    to_id_d    = BW'(i);
                    rel_v_d    = 1'b1;
                    rel_m_d    = arr_q[i];
                    state_d[i] = B_IDLE;
                    arr_d[i]   = '0;
                    part_d[i]  = '0;
                    cnt_d[i]   = '0;
                end
            end
        end
`endif

        for (int i = 0; i < NUM_BARRIERS; i++) begin
            armed_d[i] = (state_d[i] == B_ARMED);
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_BARRIERS; i++) begin
                state_q[i] <= B_IDLE;
                part_q[i]  <= '0;
                arr_q[i]   <= '0;
            end
            barrier_stall             <= 1'b0;
            barrier_warp_mask         <= '0;
            barrier_release_valid     <= 1'b0;
            barrier_release_warp_mask <= '0;
            error_valid               <= 1'b0;
            error_code                <= 2'd0;
            error_warp_id             <= 6'd0;
            armed_mask                <= '0;
        end else begin
            for (int i = 0; i < NUM_BARRIERS; i++) begin
                state_q[i] <= state_d[i];
                part_q[i]  <= part_d[i];
                arr_q[i]   <= arr_d[i];
            end
            barrier_stall             <= stall_d;
            barrier_warp_mask         <= wmask_d;
            barrier_release_valid     <= rel_v_d;
            barrier_release_warp_mask <= rel_m_d;
            error_valid               <= err_v_d;
            error_code                <= err_c_d;
            error_warp_id             <= err_w_d;
            armed_mask                <= armed_d;
        end
    end

`ifdef WARP_BARRIER_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_BARRIERS; i++) begin
                cnt_q[i] <= '0;
            end
            timeout_valid      <= 1'b0;
            timeout_barrier_id <= '0;
        end else begin
            for (int i = 0; i < NUM_BARRIERS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            timeout_valid      <= to_v_d;
            timeout_barrier_id <= to_id_d;
        end
    end
`else
    assign timeout_valid      = 1'b0;
    assign timeout_barrier_id = '0;
`endif

endmodule

// File: tb/tb_warp_barrier_ctrl.sv
// Directed self-checking bench for warp_barrier_ctrl with hand-computed expectations.
module tb_warp_barrier_ctrl;

    localparam int unsigned NW = 32;
    localparam int unsigned NB = 4;
    localparam int unsigned BW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [BW-1:0] cfg_barrier_id = '0;
    logic [NW-1:0] cfg_warp_mask = '0;
    logic          arrive_valid = 1'b0;
    logic          arrive_ready;
    logic [5:0]    arrive_warp_id = '0;
    logic [BW-1:0] arrive_barrier_id = '0;
    logic          barrier_stall;
    logic [NW-1:0] barrier_warp_mask;
    logic          barrier_release_valid;
    logic [NW-1:0] barrier_release_warp_mask;
    logic          error_valid;
    logic [1:0]    error_code;
    logic [5:0]    error_warp_id;
    logic [NB-1:0] armed_mask;
    logic          timeout_valid;
    logic [BW-1:0] timeout_barrier_id;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    warp_barrier_ctrl #(
        .NUM_WARPS(NW), .NUM_BARRIERS(NB), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_barrier_id(cfg_barrier_id), .cfg_warp_mask(cfg_warp_mask),
        .arrive_valid(arrive_valid), .arrive_ready(arrive_ready),
        .arrive_warp_id(arrive_warp_id), .arrive_barrier_id(arrive_barrier_id),
        .barrier_stall(barrier_stall), .barrier_warp_mask(barrier_warp_mask),
        .barrier_release_valid(barrier_release_valid),
        .barrier_release_warp_mask(barrier_release_warp_mask),
        .error_valid(error_valid), .error_code(error_code), .error_warp_id(error_warp_id),
        .armed_mask(armed_mask),
        .timeout_valid(timeout_valid), .timeout_barrier_id(timeout_barrier_id)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cfg(input logic [BW-1:0] b, input logic [NW-1:0] m);
        cfg_valid = 1'b1; cfg_barrier_id = b; cfg_warp_mask = m;
        tick();
        cfg_valid = 1'b0; cfg_warp_mask = '0;
    endtask

    task automatic do_arrive(input logic [5:0] w, input logic [BW-1:0] b);
        arrive_valid = 1'b1; arrive_warp_id = w; arrive_barrier_id = b;
        tick();
        arrive_valid = 1'b0;
    endtask

    task automatic expect_stall(input string tag, input logic [NW-1:0] m);
        check({tag, "_stall"}, 64'(barrier_stall), 64'd1);
        check({tag, "_smask"}, 64'(barrier_warp_mask), 64'(m));
        check({tag, "_rel"}, 64'(barrier_release_valid), 64'd0);
        check({tag, "_err"}, 64'(error_valid), 64'd0);
    endtask

    task automatic expect_release(input string tag, input logic [NW-1:0] m);
        check({tag, "_rel"}, 64'(barrier_release_valid), 64'd1);
        check({tag, "_rmask"}, 64'(barrier_release_warp_mask), 64'(m));
        check({tag, "_stall"}, 64'(barrier_stall), 64'd0);
        check({tag, "_to"}, 64'(timeout_valid), 64'd0);
    endtask

    task automatic expect_error(input string tag, input logic [1:0] c, input logic [5:0] w);
        check({tag, "_err"}, 64'(error_valid), 64'd1);
        check({tag, "_code"}, 64'(error_code), 64'(c));
        check({tag, "_wid"}, 64'(error_warp_id), 64'(w));
        check({tag, "_stall"}, 64'(barrier_stall), 64'd0);
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_stall", 64'(barrier_stall), 64'd0);
        check("rst_rel", 64'(barrier_release_valid), 64'd0);
        check("rst_err", 64'(error_valid), 64'd0);
        check("rst_armed", 64'(armed_mask), 64'd0);
        check("rst_cfg_rdy", 64'(cfg_ready), 64'd1);
        check("rst_arr_rdy", 64'(arrive_ready), 64'd1);
        check("rst_to", 64'(timeout_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Basic four-warp barrier on b0
        do_cfg(2'd0, 32'h0000_000F);
        check("t1_armed", 64'(armed_mask), 64'h1);
        do_arrive(6'd0, 2'd0); expect_stall("t1_w0", 32'h1);
        do_arrive(6'd1, 2'd0); expect_stall("t1_w1", 32'h2);
        do_arrive(6'd2, 2'd0); expect_stall("t1_w2", 32'h4);
        do_arrive(6'd3, 2'd0); expect_release("t1_w3", 32'hF);
        check("t1_armed_after", 64'(armed_mask), 64'h0);
        tick();
        check("t1_rel_pulse", 64'(barrier_release_valid), 64'd0);
        check("t1_stall_idle", 64'(barrier_stall), 64'd0);

        // Error classes
        do_arrive(6'd5, 2'd1); expect_error("t2_idle", 2'd1, 6'd5);
        do_cfg(2'd1, 32'h0);
        check("t2_zero_mask", 64'(armed_mask), 64'h0);
        do_cfg(2'd1, 32'h3);
        check("t2_armed", 64'(armed_mask), 64'h2);
        do_arrive(6'd7, 2'd1); expect_error("t2_nonpart", 2'd2, 6'd7);
        do_arrive(6'd0, 2'd1); expect_stall("t2_w0", 32'h1);
        do_arrive(6'd0, 2'd1); expect_error("t2_dup", 2'd3, 6'd0);
        do_arrive(6'd1, 2'd1); expect_release("t2_w1", 32'h3);

        // Same-cycle cfg and arrive to b2: cfg wins
        cfg_valid = 1'b1; cfg_barrier_id = 2'd2; cfg_warp_mask = 32'h10;
        arrive_valid = 1'b1; arrive_warp_id = 6'd4; arrive_barrier_id = 2'd2;
        #1;
        check("t3_arr_rdy", 64'(arrive_ready), 64'd0);
        check("t3_cfg_rdy", 64'(cfg_ready), 64'd1);
        tick();
        cfg_valid = 1'b0; arrive_valid = 1'b0;
        check("t3_armed", 64'(armed_mask), 64'h4);
        check("t3_no_stall", 64'(barrier_stall), 64'd0);
        check("t3_no_err", 64'(error_valid), 64'd0);
        cfg_valid = 1'b1; cfg_barrier_id = 2'd2; cfg_warp_mask = 32'hFF;
        #1;
        check("t3_cfg_busy", 64'(cfg_ready), 64'd0);
        check("t3_arr_rdy_busy", 64'(arrive_ready), 64'd1);
        tick();
        cfg_valid = 1'b0;
        do_arrive(6'd4, 2'd2); expect_release("t3_w4", 32'h10);

        // Interleaved b0 and b3
        do_cfg(2'd0, 32'h3);
        do_cfg(2'd3, 32'hC0);
        check("t4_armed", 64'(armed_mask), 64'h9);
        do_arrive(6'd0, 2'd0); expect_stall("t4_w0", 32'h1);
        do_arrive(6'd6, 2'd3); expect_stall("t4_w6", 32'h40);
        do_arrive(6'd1, 2'd0); expect_release("t4_w1", 32'h3);
        check("t4_armed_mid", 64'(armed_mask), 64'h8);
        do_arrive(6'd7, 2'd3); expect_release("t4_w7", 32'hC0);
        check("t4_armed_end", 64'(armed_mask), 64'h0);

        // Asynchronous reset mid-barrier
        do_cfg(2'd0, 32'hF);
        do_arrive(6'd0, 2'd0);
        do_arrive(6'd1, 2'd0);
        do_arrive(6'd2, 2'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_stall", 64'(barrier_stall), 64'd0);
        check("t5_mask", 64'(barrier_warp_mask), 64'd0);
        check("t5_armed", 64'(armed_mask), 64'd0);
        check("t5_cfg_rdy", 64'(cfg_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        cfg_valid = 1'b1; cfg_barrier_id = 2'd0; cfg_warp_mask = 32'h3;
        #1;
        check("t5_cfg_rdy_after", 64'(cfg_ready), 64'd1);
        tick();
        cfg_valid = 1'b0;
        check("t5_rearmed", 64'(armed_mask), 64'h1);
        do_arrive(6'd1, 2'd0); expect_stall("t5_w1", 32'h2);
        do_arrive(6'd0, 2'd0); expect_release("t5_w0", 32'h3);

`ifdef WARP_BARRIER_TIMEOUT_EN
        // Watchdog release of a hung barrier
        begin
            bit seen;
            seen = 1'b0;
            do_cfg(2'd1, 32'hF);
            do_arrive(6'd2, 2'd1); expect_stall("t6_w2", 32'h4);
            for (int i = 0; i < 40 && !seen; i++) begin
                if (timeout_valid) seen = 1'b1;
                else tick();
            end
            check("t6_seen", 64'(seen), 64'd1);
            check("t6_rel", 64'(barrier_release_valid), 64'd1);
            check("t6_rmask", 64'(barrier_release_warp_mask), 64'h4);
            check("t6_id", 64'(timeout_barrier_id), 64'd1);
            tick();
            check("t6_armed", 64'(armed_mask), 64'h0);
        end
`else
        tick();
        check("t6_to_off", 64'(timeout_valid), 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
